// File: rtl/led_scan_rx.sv
// led_scan_rx
//   Receive side of a multiplexed 7-segment scan bus. Samples the one-hot
//   DIGIT strobe and BCD nibble on each CE step, checks that digits arrive
//   in order 0..7, and reassembles them into a 32-bit BCD word. It can
//   require CONFIRM identical consecutive frames before publishing.
//
// Parameters
//   CONFIRM   identical consecutive frames needed before TIME updates (1..15)
//   TIMEOUT   idle CLK cycles in ASSEMBLE before lock is dropped (0 = off)
//   CHECK_BCD when 1, nibbles 4'hA..4'hF are protocol errors
//
// Ports
//   CLK    clock, rising edge
//   RST    synchronous active-low reset
//   CE     scan-step strobe; DIGIT/BCD are sampled only when CE=1
//   DIGIT  one-hot digit select, bit n = digit n
//   BCD    nibble for the selected digit
//   TIME   last published frame, digit n in bits [4n+3:4n]
//   VALID  one-cycle pulse when TIME is loaded
//   ERR    one-cycle pulse on a protocol error
//   LOCK   high after a complete error-free frame, low after error/timeout
module led_scan_rx #(
    parameter int unsigned CONFIRM   = 1,
    parameter int unsigned TIMEOUT   = 1000,
    parameter bit          CHECK_BCD = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [7:0]  DIGIT,
    input  logic [3:0]  BCD,
    output logic [31:0] TIME,
    output logic        VALID,
    output logic        ERR,
    output logic        LOCK
);

    typedef enum logic {HUNT = 1'b0, ASSEMBLE = 1'b1} state_t;

    localparam logic [3:0]  CONF = 4'(CONFIRM);
    localparam logic [16:0] TO   = 17'(TIMEOUT);

    state_t      state_q, state_d;
    logic [2:0]  exp_q, exp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] prev_q, prev_d;
    logic [3:0]  match_q, match_d;
    logic [15:0] idle_q, idle_d;
    logic [31:0] time_d;
    logic        valid_d, err_d, lock_d;

    // Sample decode
    logic        onehot, bcd_ok, smp_ok;
    logic [2:0]  idx;
    logic [31:0] frame;
    logic [3:0]  match_inc;

    always_comb begin
        onehot = (DIGIT != 8'd0) && ((DIGIT & (DIGIT - 8'd1)) == 8'd0);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++)
            if (DIGIT[i]) idx = 3'(i);
        bcd_ok = !CHECK_BCD || (BCD <= 4'd9);
        smp_ok = onehot && bcd_ok;
        // Shadow with the current nibble merged in at the expected slot;
        // at index 7 this is the completed frame.
        frame = shadow_q;
        frame[{exp_q, 2'b00} +: 4] = BCD;
        match_inc = (match_q >= CONF) ? CONF : match_q + 4'd1;
    end

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        prev_d   = prev_q;
        match_d  = match_q;
        idle_d   = idle_q;
        time_d   = TIME;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        lock_d   = LOCK;
        case (state_q)
            HUNT: begin
                idle_d = 16'd0;
                // Anything but a clean index-0 sample is silently ignored.
                if (CE && smp_ok && idx == 3'd0) begin
                    shadow_d = {28'd0, BCD};
                    exp_d    = 3'd1;
                    state_d  = ASSEMBLE;
                end
            end
            ASSEMBLE: begin
                if (CE) begin
                    // A CE sample always wins over a coincident timeout.
                    idle_d = 16'd0;
                    if (smp_ok && idx == exp_q) begin
                        shadow_d = frame;
                        exp_d    = exp_q + 3'd1;
                        if (exp_q == 3'd7) begin
                            prev_d  = frame;
                            lock_d  = 1'b1;
                            match_d = (frame == prev_q) ? match_inc : 4'd1;
                            if (match_d == CONF) begin
                                time_d  = frame;
                                valid_d = 1'b1;
                            end
                        end
                    end else begin
                        err_d   = 1'b1;
                        lock_d  = 1'b0;
                        match_d = 4'd0;
                        if (smp_ok && idx == 3'd0) begin
                            // Out-of-place digit 0 starts a fresh frame.
                            shadow_d = {28'd0, BCD};
                            exp_d    = 3'd1;
                        end else begin
                            shadow_d = 32'd0;
                            exp_d    = 3'd0;
                            state_d  = HUNT;
                        end
                    end
                end else if (TIMEOUT != 0) begin
                    if ({1'b0, idle_q} + 17'd1 == TO) begin
                        state_d  = HUNT;
                        lock_d   = 1'b0;
                        match_d  = 4'd0;
                        idle_d   = 16'd0;
                        exp_d    = 3'd0;
                        shadow_d = 32'd0;
                    end else begin
                        idle_d = idle_q + 16'd1;
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= HUNT;
            exp_q    <= 3'd0;
            shadow_q <= 32'd0;
            prev_q   <= 32'd0;
            match_q  <= 4'd0;
            idle_q   <= 16'd0;
            TIME     <= 32'd0;
            VALID    <= 1'b0;
            ERR      <= 1'b0;
            LOCK     <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            idle_q   <= idle_d;
            TIME     <= time_d;
            VALID    <= valid_d;
            ERR      <= err_d;
            LOCK     <= lock_d;
        end
    end

endmodule

// File: doc/led_scan_rx.md
# led_scan_rx

Receive side of the multiplexed 7-segment display bus: samples the scanned `DIGIT` one-hot strobe and `BCD` nibble on each scan step and reassembles the eight digits into a 32-bit BCD `TIME` word. It sits on the far side of the display scan bus, for example in a display-monitor or self-check path. It checks the scan sequence, flags protocol errors and optionally requires several identical consecutive frames before publishing.

## Interface
- `CONFIRM`, default 1: identical consecutive complete frames required before `TIME` updates; legal range 1..15.
- `TIMEOUT`, default 1000: `CLK` cycles without `CE` while in ASSEMBLE before the receiver drops lock; 0 disables; legal range 0..65535.
- `CHECK_BCD`, default 1: when 1, nibble values 4'hA..4'hF are protocol errors.

- `CLK`  in  1  single clock; all state changes on rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `CE`  in  1  scan-step strobe; `DIGIT`/`BCD` are sampled only on edges where `CE`=1.
- `DIGIT`  in  8  one-hot digit select; bit n means digit index n.
- `BCD`  in  4  nibble for the selected digit.
- `TIME`  out  32  last published frame; digit n occupies bits [4n+3:4n].
- `VALID`  out  1  one-cycle pulse when `TIME` is updated.
- `ERR`  out  1  one-cycle pulse on a protocol error.
- `LOCK`  out  1  level; 1 after the first complete error-free frame, 0 after an error, timeout or reset.

## Operation
- States:
  - HUNT: wait for a sample with `DIGIT`=8'b0000_0001.
  - ASSEMBLE: collect digits, with an expected index `exp` of 3 bits.
- Sample on `CE`=1:
  - Index decode: one-hot `DIGIT` maps to index 0..7.
  - Invalid sample: zero bits or more than one bit set in `DIGIT`, or (with `CHECK_BCD`) `BCD`>9.
- HUNT:
  - Valid index-0 sample: store the nibble in shadow[3:0], set `exp`=1, go to ASSEMBLE.
  - Any other sample: ignored silently, no `ERR`.
- ASSEMBLE, valid sample with index==`exp`:
  - Store the nibble in shadow[4·exp+3:4·exp] and increment `exp`; 7→0 wraps.
  - When index 7 is stored, the frame is complete. Compare the frame with the previous complete frame:
    - If equal, increment `match_cnt`, saturating at `CONFIRM`.
    - Otherwise set `match_cnt`=1.
  - When `match_cnt` reaches `CONFIRM`, load `TIME` with the frame and pulse `VALID`. Publish once per qualifying frame; with `CONFIRM`=1 every frame publishes.
  - Set `LOCK`=1 on every complete frame. Stay in ASSEMBLE expecting index 0.
- ASSEMBLE, invalid sample or index≠`exp`:
  - Pulse `ERR`, set `LOCK`=0, set `match_cnt`=0 and discard the shadow.
  - If the offending sample is a valid index-0 sample, resynchronise: store it and set `exp`=1, staying in ASSEMBLE.
  - Otherwise go to HUNT.
- Timeout, `TIMEOUT`≠0, in ASSEMBLE:
  - An idle counter clears on every `CE` and increments on every other cycle.
  - On reaching `TIMEOUT`: go to HUNT, set `LOCK`=0, set `match_cnt`=0. No `ERR` pulse.
- `TIME` is never modified by errors, timeouts or partial frames.

## Timing
- Reset values while `RST`=0 at an edge: `TIME`=0, `VALID`=0, `ERR`=0, `LOCK`=0, state HUNT, `exp`=0, `match_cnt`=0, idle counter 0, previous-frame register 0. Reset overrides `CE`.
- Reset asserted mid-frame abandons the partial frame with no `VALID`/`ERR`.
- Latency: `TIME`, `VALID` and `LOCK` change at the same edge that samples digit 7. `VALID` is high for exactly that one cycle.
- `ERR` is registered at the sampling edge and high for one cycle. `VALID` and `ERR` are never high together.
- Simultaneous timeout expiry and `CE`: the `CE` sample is processed and the timeout ignored.
- All outputs are registered; there are no combinational input-to-output paths.
- Back-to-back `CE` (every cycle) is supported at full rate.

## Test plan
- Reset: hold `RST`=0 for 3 cycles with random `CE`/`DIGIT` activity -> `TIME`=0, `VALID`=0, `ERR`=0, `LOCK`=0.
- Clean frame, `CONFIRM`=1: 8 `CE` samples, indices 0..7, nibbles 8,7,6,5,4,3,2,1 -> single `VALID` at the digit-7 edge, `TIME`=32'h1234_5678, `LOCK`=1; a second identical frame produces a second `VALID`.
- Mid-frame start: begin at index 3 and run 3..7,0..7 -> no `ERR` during 3..7, first `VALID` only after the following full 0..7 sequence.
- Errors after lock:
  - `DIGIT`=8'b0000_0110 -> `ERR` pulse, `LOCK`=0, `TIME` unchanged.
  - Indices 0,1,3 -> `ERR` at index 3, HUNT.
  - `BCD`=4'hA with `CHECK_BCD`=1 -> `ERR`.
  - Index 0 arriving while `exp`=4 -> `ERR`, then the next 1..7 completes a frame with `VALID`.
- `CONFIRM`=2: frames 0x00000001, 0x00000002, 0x00000002 -> no `VALID` after frame 1 or the first frame 2; `VALID` with `TIME`=32'h0000_0002 after the second frame 2.
- `TIMEOUT`=10: stop `CE` after index 4 -> `LOCK`=0 on the 10th idle cycle with no `ERR`; the next index-5 sample is ignored in HUNT.
